// File: rtl/present_arb_pkg.sv
// Shared types and constants for the PRESENT-80 two-requester arbiter/controller.
package present_arb_pkg;

  localparam int PKG_BLOCK_W = 64;
  localparam int PKG_KEY_W   = 80;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

  typedef logic req_idx_t;

  function automatic logic [1:0] idx_onehot(input req_idx_t idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin picker; the last-grant pointer is owned by the caller.
module rr_arbiter2
  import present_arb_pkg::*;
(
  input  logic [1:0] req_valid,
  input  req_idx_t   last_grant,
  output req_idx_t   grant,
  output logic       grant_valid
);

  always_comb begin
    grant_valid = |req_valid;
    if (req_valid == 2'b11) begin
      grant = ~last_grant;
    end else begin
      grant = req_valid[1];
    end
  end

endmodule

// File: rtl/present_arb_ctrl.sv
// Shares one iterative PRESENT-80 core between two requesters (round-robin).
// Optional BUSY watchdog enabled with `define PRESENT_ARB_TIMEOUT_EN.
module present_arb_ctrl
  import present_arb_pkg::*;
#(
  parameter int BLOCK_W        = PKG_BLOCK_W,
  parameter int KEY_W          = PKG_KEY_W,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [2*BLOCK_W-1:0] req_plain_text,
  input  logic [2*KEY_W-1:0]   req_master_key,
  output logic [1:0]           rsp_valid,
  input  logic [1:0]           rsp_ready,
  output logic [BLOCK_W-1:0]   rsp_data,
  output logic                 err,
  output logic                 busy,
  output logic                 core_start,
  output logic [BLOCK_W-1:0]   core_plain_text,
  output logic [KEY_W-1:0]     core_master_key,
  input  logic [BLOCK_W-1:0]   core_out,
  input  logic                 core_done
);

  arb_state_e         state_q, state_d;
  req_idx_t           last_grant_q, last_grant_d;
  req_idx_t           grant_q, grant_d;
  logic [BLOCK_W-1:0] pt_q, pt_d;
  logic [KEY_W-1:0]   key_q, key_d;
  logic [BLOCK_W-1:0] rsp_data_q, rsp_data_d;

  req_idx_t arb_grant;
  logic     arb_valid;

`ifdef PRESENT_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
`endif

  rr_arbiter2 u_arb (
    .req_valid   (req_valid),
    .last_grant  (last_grant_q),
    .grant       (arb_grant),
    .grant_valid (arb_valid)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    pt_d         = pt_q;
    key_d        = key_q;
    rsp_data_d   = rsp_data_q;
    req_ready    = 2'b00;
`ifdef PRESENT_ARB_TIMEOUT_EN
    cnt_d        = cnt_q;
    err_d        = err_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        // Accept strobe is masked while reset is asserted so every output reads 0.
        if (rst && arb_valid) begin
          req_ready = idx_onehot(arb_grant);
          grant_d   = arb_grant;
          pt_d      = arb_grant ? req_plain_text[2*BLOCK_W-1:BLOCK_W] : req_plain_text[BLOCK_W-1:0];
          key_d     = arb_grant ? req_master_key[2*KEY_W-1:KEY_W] : req_master_key[KEY_W-1:0];
          state_d   = ST_BUSY;
`ifdef PRESENT_ARB_TIMEOUT_EN
          cnt_d     = '0;
`endif
        end
      end

      ST_BUSY: begin
        if (core_done) begin
          rsp_data_d = core_out;
          state_d    = ST_RESP;
`ifdef PRESENT_ARB_TIMEOUT_EN
          err_d      = 1'b0;
`endif
        end
`ifdef PRESENT_ARB_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          // Last permitted BUSY cycle without completion: answer with an error.
          rsp_data_d = '0;
          err_d      = 1'b1;
          state_d    = ST_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end

      ST_RESP: begin
        if (rsp_ready[grant_q]) begin
          last_grant_d = grant_q;
          state_d      = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      pt_q         <= '0;
      key_q        <= '0;
      rsp_data_q   <= '0;
`ifdef PRESENT_ARB_TIMEOUT_EN
      cnt_q        <= '0;
      err_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      pt_q         <= pt_d;
      key_q        <= key_d;
      rsp_data_q   <= rsp_data_d;
`ifdef PRESENT_ARB_TIMEOUT_EN
      cnt_q        <= cnt_d;
      err_q        <= err_d;
`endif
    end
  end

  assign busy            = (state_q != ST_IDLE);
  assign core_start      = (state_q == ST_BUSY);
  assign rsp_valid       = (state_q == ST_RESP) ? idx_onehot(grant_q) : 2'b00;
  assign rsp_data        = rsp_data_q;
  assign core_plain_text = pt_q;
  assign core_master_key = key_q;

`ifdef PRESENT_ARB_TIMEOUT_EN
  assign err = err_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_present_arb_ctrl.sv
// Self-checking bench for present_arb_ctrl with a behavioural PRESENT-80 core stub.
module tb_present_arb_ctrl;

  localparam int TMO = 16;
  localparam logic [3:0] SBOX [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                       4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
  logic [127:0] req_plain_text;
  logic [159:0] req_master_key;
  logic [63:0]  rsp_data, core_plain_text, core_out;
  logic [79:0]  core_master_key;
  logic         err, busy, core_start, core_done;

  int  n_chk = 0;
  int  n_err = 0;
  int  stub_lat = 3;
  bit  stub_hang = 1'b0;
  bit  stub_run;
  int  stub_cnt;

  present_arb_ctrl #(.BLOCK_W(64), .KEY_W(80), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_plain_text(req_plain_text), .req_master_key(req_master_key),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .err(err), .busy(busy), .core_start(core_start),
    .core_plain_text(core_plain_text), .core_master_key(core_master_key),
    .core_out(core_out), .core_done(core_done)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] present80(input logic [63:0] pt, input logic [79:0] key);
    logic [63:0] s, p;
    logic [79:0] k;
    s = pt;
    k = key;
    for (int r = 1; r <= 31; r++) begin
      s = s ^ k[79:16];
      for (int n = 0; n < 16; n++) s[4*n +: 4] = SBOX[s[4*n +: 4]];
      p = '0;
      for (int i = 0; i < 64; i++) p[(i == 63) ? 63 : (i * 16) % 63] = s[i];
      s = p;
      k = {k[18:0], k[79:19]};
      k[79:76] = SBOX[k[79:76]];
      k[19:15] = k[19:15] ^ 5'(r);
    end
    return s ^ k[79:16];
  endfunction

  function automatic logic [1:0] oh(input int g);
    return (g != 0) ? 2'b10 : 2'b01;
  endfunction

  // Round-robin rule: the sole requester, or the one not served last when both ask.
  function automatic int pick(input logic [1:0] v, input int last);
    if (v == 2'b11) return 1 - last;
    return v[1] ? 1 : 0;
  endfunction

  // Cipher core stand-in: answers a held start after a programmable latency.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      stub_run  <= 1'b0;
      stub_cnt  <= 0;
      core_done <= 1'b0;
      core_out  <= '0;
    end else begin
      core_done <= 1'b0;
      core_out  <= {$urandom, $urandom};
      if (!core_start) begin
        stub_run <= 1'b0;
      end else if (stub_run) begin
        if (stub_cnt > 1) begin
          stub_cnt <= stub_cnt - 1;
        end else if (!stub_hang) begin
          core_done <= 1'b1;
          core_out  <= present80(core_plain_text, core_master_key);
          stub_run  <= 1'b0;
        end
      end else if (!core_done) begin
        stub_run <= 1'b1;
        stub_cnt <= stub_lat;
      end
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, req_ready, 2'b00);
    chk({tag, "_rsp_valid"}, rsp_valid, 2'b00);
    chk({tag, "_rsp_data"}, rsp_data, 64'h0);
    chk({tag, "_err"}, err, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_core_start"}, core_start, 1'b0);
    chk({tag, "_core_pt"}, core_plain_text, 64'h0);
    chk({tag, "_core_key"}, core_master_key, 80'h0);
  endtask

  // Called at a falling edge with the winning request already driven.
  task automatic run_txn(input int g, input logic [63:0] exp_ct, input int hold,
                         input logic [1:0] vld_during, input bit tmo);
    logic [63:0] xpt;
    logic [79:0] xkey;
    int cyc;
    int done_at;
    xpt  = (g != 0) ? req_plain_text[127:64] : req_plain_text[63:0];
    xkey = (g != 0) ? req_master_key[159:80] : req_master_key[79:0];
    #1;
    chk("accept_ready", req_ready, oh(g));
    chk("accept_start_low", core_start, 1'b0);
    @(negedge clk);
    req_valid = vld_during;
    #1;
    cyc = 0;
    done_at = -1;
    while (rsp_valid == 2'b00 && cyc < 200) begin
      chk("busy_start", core_start, 1'b1);
      chk("busy_flag", busy, 1'b1);
      chk("busy_no_ready", req_ready, 2'b00);
      chk("busy_pt", core_plain_text, xpt);
      chk("busy_key", core_master_key, xkey);
      if (core_done && done_at < 0) done_at = cyc;
      @(negedge clk);
      #1;
      cyc++;
    end
    chk("rsp_who", rsp_valid, oh(g));
    if (tmo) chk("tmo_busy_cycles", cyc, TMO);
    else     chk("rsp_latency", cyc, done_at + 1);
    chk("rsp_data", rsp_data, exp_ct);
    chk("rsp_err", err, tmo);
    chk("rsp_start_low", core_start, 1'b0);
    for (int i = 0; i < hold; i++) begin
      rsp_ready = oh(1 - g);
      @(negedge clk);
      #1;
      chk("hold_valid", rsp_valid, oh(g));
      chk("hold_data", rsp_data, exp_ct);
      chk("hold_err", err, tmo);
      chk("hold_no_ready", req_ready, 2'b00);
    end
    rsp_ready = oh(g) | 2'($urandom_range(0, 3));
    @(negedge clk);
    rsp_ready = 2'b00;
  endtask

  typedef struct {
    int          g;
    logic [63:0] pt;
    logic [79:0] key;
    logic [63:0] ct;
    int          hold;
  } kat_t;

  kat_t kat [4];

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [1:0]  exp_rdy;
    logic [63:0] cap_pt, exp_ct;
    logic [79:0] cap_key;
    bit          outstanding;
    int          og, last, age;

    kat[0] = '{0, 64'h0, 80'h0, 64'h5579C1387B228445, 0};
    kat[1] = '{1, 64'h0, {80{1'b1}}, 64'hE72C46C0F5945049, 1};
    kat[2] = '{0, {64{1'b1}}, 80'h0, 64'hA112FFC72F68417B, 3};
    kat[3] = '{1, {64{1'b1}}, {80{1'b1}}, 64'h3333DCD3213210D2, 0};

    rst = 1'b0;
    req_valid = 2'b11;
    rsp_ready = 2'b00;
    req_plain_text = '0;
    req_master_key = '0;
    repeat (2) @(negedge clk);
    #1;
    chk_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b1;

    // Both requesters continuously valid: service alternates starting with 0.
    req_plain_text = '0;
    req_master_key = {{80{1'b1}}, 80'h0};
    req_valid = 2'b11;
    for (int t = 0; t < 4; t++) begin
      run_txn(t % 2, (t % 2 != 0) ? 64'hE72C46C0F5945049 : 64'h5579C1387B228445,
              (t == 1) ? 2 : 0, 2'b11, 1'b0);
    end

    // Known-answer table, one requester at a time, varied response back-pressure.
    req_valid = 2'b00;
    for (int i = 0; i < 4; i++) begin
      req_plain_text = {$urandom, $urandom, $urandom, $urandom};
      req_master_key = {$urandom, $urandom, $urandom, $urandom, $urandom};
      if (kat[i].g != 0) begin
        req_plain_text[127:64] = kat[i].pt;
        req_master_key[159:80] = kat[i].key;
      end else begin
        req_plain_text[63:0] = kat[i].pt;
        req_master_key[79:0] = kat[i].key;
      end
      stub_lat = 1 + i * 2;
      req_valid = oh(kat[i].g);
      run_txn(kat[i].g, kat[i].ct, kat[i].hold, 2'b00, 1'b0);
      req_valid = 2'b00;
    end

    // Response stalled 5 cycles while requester 1 waits; it is granted right after.
    req_plain_text = {{64{1'b1}}, 64'h0};
    req_master_key = {{80{1'b1}}, 80'h0};
    req_valid = 2'b01;
    run_txn(0, 64'h5579C1387B228445, 5, 2'b10, 1'b0);
    run_txn(1, 64'h3333DCD3213210D2, 0, 2'b00, 1'b0);

    // Asynchronous reset in the middle of BUSY.
    req_plain_text = '0;
    req_master_key = '0;
    stub_lat = 10;
    req_valid = 2'b01;
    #1;
    chk("abort_accept", req_ready, 2'b01);
    repeat (3) @(negedge clk);
    #1;
    chk("abort_in_busy", core_start, 1'b1);
    #1;
    rst = 1'b0;
    #1;
    chk_reset_outputs("abort");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    stub_lat = 3;
    req_plain_text[63:0] = {64{1'b1}};
    req_valid = 2'b01;
    run_txn(0, 64'hA112FFC72F68417B, 0, 2'b00, 1'b0);

`ifdef PRESENT_ARB_TIMEOUT_EN
    stub_hang = 1'b1;
    req_valid = 2'b10;
    run_txn(1, 64'h0, 1, 2'b00, 1'b1);
    stub_hang = 1'b0;
    req_master_key = {{80{1'b1}}, 80'h0};
    req_plain_text = '0;
    req_valid = 2'b10;
    run_txn(1, 64'hE72C46C0F5945049, 0, 2'b00, 1'b0);
`endif

    // Random traffic against a transaction-level scoreboard.
    req_valid = 2'b00;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    last = 1;
    outstanding = 1'b0;
    og = 0;
    age = 0;
    cap_pt = '0;
    cap_key = '0;
    exp_ct = '0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      req_valid      = 2'($urandom_range(0, 3));
      rsp_ready      = 2'($urandom_range(0, 3));
      req_plain_text = {$urandom, $urandom, $urandom, $urandom};
      req_master_key = {$urandom, $urandom, $urandom, $urandom, $urandom};
      stub_lat       = $urandom_range(1, 4);
      #1;
      if (!outstanding) begin
        exp_rdy = (req_valid == 2'b00) ? 2'b00 : oh(pick(req_valid, last));
        chk("rnd_ready", req_ready, exp_rdy);
        chk("rnd_idle_rspv", rsp_valid, 2'b00);
        if (req_valid != 2'b00) begin
          og      = pick(req_valid, last);
          cap_pt  = (og != 0) ? req_plain_text[127:64] : req_plain_text[63:0];
          cap_key = (og != 0) ? req_master_key[159:80] : req_master_key[79:0];
          exp_ct  = present80(cap_pt, cap_key);
          outstanding = 1'b1;
          age = 0;
        end
      end else begin
        chk("rnd_no_ready", req_ready, 2'b00);
        chk("rnd_core_pt", core_plain_text, cap_pt);
        chk("rnd_core_key", core_master_key, cap_key);
        age++;
        chk("rnd_stall", age > 60, 1'b0);
        if (rsp_valid != 2'b00) begin
          chk("rnd_rsp_who", rsp_valid, oh(og));
          chk("rnd_rsp_data", rsp_data, exp_ct);
          chk("rnd_rsp_err", err, 1'b0);
          if (rsp_ready[og]) begin
            outstanding = 1'b0;
            last = og;
          end
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
